// File: rtl/mod_counter.sv
// mod_counter: up/down modulo-MODULUS counter with synchronous clear and load,
// free-run or one-shot terminal behaviour, and an optional saturating wrap
// counter.
//
// Optional feature macro: MOD_COUNTER_WRAPCNT_EN (adds the wrap_cnt port).
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rstn      asynchronous active-low reset
//   en        count enable
//   up        direction, 1 = up, 0 = down
//   clr       synchronous clear (highest priority)
//   load      synchronous load strobe (load_val saturated to MODULUS-1)
//   load_val  load value
//   oneshot   1 = stop at the terminal value, 0 = wrap around
//   cnt       registered count, always 0..MODULUS-1
//   tc        combinational terminal count (enabled and at the end of range)
//   carry     registered one-cycle pulse on each wrap/terminal event
//   done      registered, high while the one-shot has stopped
//   wrap_cnt  registered saturating count of carry pulses (macro builds only)
module mod_counter #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MODULUS = 18,
  parameter int unsigned WRAP_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             carry,
  output logic             done
`ifdef MOD_COUNTER_WRAPCNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt_next;
  logic             carry_next;
  logic             at_end;
  logic [WIDTH-1:0] load_sat;

  // Out-of-range load values clamp to the top of the count range.
  assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? CNT_MAX : load_val;

  always_comb begin
    at_end     = up ? (cnt == CNT_MAX) : (cnt == '0);
    tc         = en & at_end & (state == RUN);
    state_next = state;
    cnt_next   = cnt;
    carry_next = 1'b0;

    if (clr) begin
      state_next = RUN;
      cnt_next   = '0;
    end else if (load) begin
      state_next = RUN;
      cnt_next   = load_sat;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (at_end) begin
              carry_next = 1'b1;
              if (oneshot) begin
                state_next = DONE;
              end else begin
                cnt_next = up ? '0 : CNT_MAX;
              end
            end else begin
              cnt_next = up ? cnt + 1'b1 : cnt - 1'b1;
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      carry <= carry_next;
      done  <= (state_next == DONE);
    end
  end

`ifdef MOD_COUNTER_WRAPCNT_EN
  // Counts on the same edge that raises carry, so it tracks carry pulses exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrap_cnt <= '0;
    end else if (clr) begin
      wrap_cnt <= '0;
    end else if (carry_next && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
`else
  // WRAP_W stays in the parameter list so instantiations are build-independent.
  if (WRAP_W == 0) begin : g_wrap_w_unused
  end
`endif

endmodule
